tms_branch_unit: RTL and testbench

Parametrised program-counter and subroutine unit for the TMS1x00 soft-processor family. It owns PC, page (PA), page buffer (PB), chapter and chapter buffer (CB), and produces the ROM fetch address. It generalises the single-level call latch to a STACK_DEPTH-deep return stack and adds TMS1100 chapter switching. The execute state machine issues one decoded control-flow op per cycle; the unit updates all state on that cycle's edge.

---
 rtl/tms_branch_unit_if.sv | 28 ++
 rtl/tms_branch_unit.sv | 160 ++++++++++++++++
 tb/tb_tms_branch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tms_branch_unit_if.sv
// Control-flow op bus between the TMS1x00 execute sequencer and the branch unit.
// Handshake: op_valid qualifies op/op_arg/status for one cycle; there is no ready, the unit accepts one op every cycle.
interface tms_branch_unit_if #(
    parameter int CHAPTER_BITS = 1,
    parameter int STACK_DEPTH  = 1
);
    localparam int ADDR_W  = CHAPTER_BITS + 10;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               op_valid;
    logic [2:0]         op;
    logic [5:0]         op_arg;
    logic               status;
    logic [ADDR_W-1:0]  rom_addr;
    logic               in_sub;
    logic [DEPTH_W-1:0] depth;
    logic               overflow;

    modport master (
        output op_valid, op, op_arg, status,
        input  rom_addr, in_sub, depth, overflow
    );

    modport slave (
        input  op_valid, op, op_arg, status,
        output rom_addr, in_sub, depth, overflow
    );
endinterface

// File: rtl/tms_branch_unit.sv
// TMS1x00 program counter, page/chapter registers and multi-level return stack.
// Every state update happens on the edge that samples a valid op; outputs come straight from registers.
module tms_branch_unit #(
    parameter int CHAPTER_BITS = 1,
    parameter int STACK_DEPTH  = 1,
    parameter int RESET_PAGE   = 0,
    localparam int ADDR_W      = CHAPTER_BITS + 10,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    tms_branch_unit_if.slave bus
);
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RETN = 3'd3;
    localparam logic [2:0] OP_LDP  = 3'd4;
    localparam logic [2:0] OP_COMC = 3'd5;

    logic [5:0]              r_pc;
    logic [3:0]              r_page;
    logic [3:0]              r_pb;
    logic [CHAPTER_BITS-1:0] r_ch;
    logic [CHAPTER_BITS-1:0] r_cb;
    logic [DEPTH_W-1:0]      r_depth;
    logic                    r_in_sub;
    logic                    r_ovf;
    // Sized to the full depth index range so r_depth can address it directly.
    logic [ADDR_W-1:0]       r_stack [0:(1<<DEPTH_W)-1];

    logic [5:0]              w_pc_inc;
    logic [5:0]              w_pc_d;
    logic [3:0]              w_page_d;
    logic [3:0]              w_pb_d;
    logic [CHAPTER_BITS-1:0] w_ch_d;
    logic [CHAPTER_BITS-1:0] w_cb_d;
    logic [DEPTH_W-1:0]      w_depth_d;
    logic                    w_ovf_d;
    logic                    w_push;
    logic                    w_full;
    logic                    w_empty;
    logic [DEPTH_W-1:0]      w_top_idx;
    logic [ADDR_W-1:0]       w_top;

    // Shift-register PC with the two patches that make the sequence cover all 64 values.
    always_comb begin
        w_pc_inc = {r_pc[4:0], ~(r_pc[5] ^ r_pc[4])};
        if (r_pc == 6'h1F) begin
            w_pc_inc = 6'h3F;
        end else if (r_pc == 6'h3F) begin
            w_pc_inc = 6'h3E;
        end
    end

    assign w_full    = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty   = (r_depth == '0);
    assign w_top_idx = r_depth - DEPTH_W'(1);
    assign w_top     = r_stack[w_top_idx];

    always_comb begin
        w_pc_d    = r_pc;
        w_page_d  = r_page;
        w_pb_d    = r_pb;
        w_ch_d    = r_ch;
        w_cb_d    = r_cb;
        w_depth_d = r_depth;
        w_ovf_d   = r_ovf;
        w_push    = 1'b0;
        if (bus.op_valid) begin
            case (bus.op)
                OP_BR: begin
                    if (bus.status) begin
                        w_pc_d = bus.op_arg;
                        w_ch_d = r_cb;
                        if (w_empty) begin
                            w_page_d = r_pb;
                        end
                    end else begin
                        w_pc_d = w_pc_inc;
                    end
                end
                OP_CALL: begin
                    if (!bus.status) begin
                        w_pc_d = w_pc_inc;
                    end else if (!w_full) begin
                        w_push    = 1'b1;
                        w_page_d  = r_pb;
                        w_pb_d    = r_page;
                        w_ch_d    = r_cb;
                        w_pc_d    = bus.op_arg;
                        w_depth_d = r_depth + DEPTH_W'(1);
                    end else begin
                        // Full stack: degrade to an in-subroutine branch and flag it.
                        w_pc_d  = bus.op_arg;
                        w_ch_d  = r_cb;
                        w_ovf_d = 1'b1;
                    end
                end
                OP_RETN: begin
                    if (!w_empty) begin
                        w_ch_d    = w_top[ADDR_W-1:10];
                        w_cb_d    = w_top[ADDR_W-1:10];
                        w_page_d  = w_top[9:6];
                        w_pb_d    = w_top[9:6];
                        w_pc_d    = w_top[5:0];
                        w_depth_d = w_top_idx;
                    end else begin
                        w_page_d = r_pb;
                        w_pc_d   = w_pc_inc;
                    end
                end
                OP_LDP: begin
                    w_pc_d = w_pc_inc;
                    w_pb_d = bus.op_arg[3:0];
                end
                OP_COMC: begin
                    w_pc_d = w_pc_inc;
                    w_cb_d = ~r_cb;
                end
                default: begin
                    w_pc_d = w_pc_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_page   <= 4'(RESET_PAGE);
            r_pb     <= 4'(RESET_PAGE);
            r_ch     <= '0;
            r_cb     <= '0;
            r_depth  <= '0;
            r_in_sub <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_pc     <= w_pc_d;
            r_page   <= w_page_d;
            r_pb     <= w_pb_d;
            r_ch     <= w_ch_d;
            r_cb     <= w_cb_d;
            r_depth  <= w_depth_d;
            r_in_sub <= (w_depth_d != '0);
            r_ovf    <= w_ovf_d;
        end
    end

    // Stack contents are not reset; depth alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_stack[r_depth] <= {r_ch, r_page, w_pc_inc};
        end
    end

    assign bus.rom_addr = {r_ch, r_page, r_pc};
    assign bus.in_sub   = r_in_sub;
    assign bus.depth    = r_depth;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_tms_branch_unit.sv
// Bench for tms_branch_unit: a queue-based program-counter model checked every cycle,
// plus hand-computed rom_addr/depth/overflow values along the directed sequence.
module tb_tms_branch_unit;
    localparam int CB = 1;
    localparam int SD = 2;
    localparam int RP = 12;
    localparam int DW = $clog2(SD + 1);

    logic clk;
    logic reset;

    tms_branch_unit_if #(.CHAPTER_BITS(CB), .STACK_DEPTH(SD)) bus ();

    tms_branch_unit #(
        .CHAPTER_BITS (CB),
        .STACK_DEPTH  (SD),
        .RESET_PAGE   (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    typedef struct {
        int c;
        int p;
        int r;
    } ent_t;

    int   m_pc, m_page, m_pb, m_ch, m_cb, m_ovf;
    ent_t m_stk[$];

    function automatic int nxt(input int pc);
        if (pc == 31) return 63;
        if (pc == 63) return 62;
        return ((pc << 1) & 63) | ((~((pc >> 5) ^ (pc >> 4))) & 1);
    endfunction

    task automatic model_apply(input bit rst, input bit v, input int op, input int arg, input bit st);
        ent_t e;
        int   t;
        if (rst) begin
            m_pc = 0; m_page = RP; m_pb = RP; m_ch = 0; m_cb = 0; m_ovf = 0;
            m_stk.delete();
        end else if (v) begin
            case (op)
                1: begin
                    if (st) begin
                        m_pc = arg; m_ch = m_cb;
                        if (m_stk.size() == 0) m_page = m_pb;
                    end else m_pc = nxt(m_pc);
                end
                2: begin
                    if (!st) m_pc = nxt(m_pc);
                    else if (m_stk.size() < SD) begin
                        e.c = m_ch; e.p = m_page; e.r = nxt(m_pc);
                        m_stk.push_back(e);
                        t = m_page; m_page = m_pb; m_pb = t;
                        m_ch = m_cb; m_pc = arg;
                    end else begin
                        m_pc = arg; m_ch = m_cb; m_ovf = 1;
                    end
                end
                3: begin
                    if (m_stk.size() > 0) begin
                        e = m_stk.pop_back();
                        m_ch = e.c; m_cb = e.c; m_page = e.p; m_pb = e.p; m_pc = e.r;
                    end else begin
                        m_page = m_pb; m_pc = nxt(m_pc);
                    end
                end
                4: begin m_pc = nxt(m_pc); m_pb = arg & 15; end
                5: begin m_pc = nxt(m_pc); m_cb = m_cb ^ ((1 << CB) - 1); end
                default: m_pc = nxt(m_pc);
            endcase
        end
    endtask

    // ---------------- driver ----------------
    bit chk_en;
    bit pin_valid;
    int pin_rom, pin_depth, pin_ovf;

    task automatic stepx(input bit rst, input bit v, input int op, input int arg, input bit st,
                         input bit pe, input int prom, input int pdep, input int povf);
        reset        = rst;
        bus.op_valid = v;
        bus.op       = 3'(op);
        bus.op_arg   = 6'(arg);
        bus.status   = st;
        @(posedge clk);
        #1;
        model_apply(rst, v, op, arg, st);
        pin_valid = pe;
        pin_rom   = prom;
        pin_depth = pdep;
        pin_ovf   = povf;
        chk_en    = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input int op, input int arg, input bit st);
        stepx(1'b0, 1'b1, op, arg, st, 1'b0, 0, 0, 0);
    endtask

    task automatic stepp(input int op, input int arg, input bit st, input int prom, input int pdep, input int povf);
        stepx(1'b0, 1'b1, op, arg, st, 1'b1, prom, pdep, povf);
    endtask

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_addr", int'(bus.rom_addr), (m_ch << 10) | (m_page << 6) | m_pc);
            chk("depth", int'(bus.depth), m_stk.size());
            chk("in_sub", int'(bus.in_sub), (m_stk.size() != 0) ? 1 : 0);
            chk("overflow", int'(bus.overflow), m_ovf);
            if (pin_valid) begin
                chk("pin_rom_addr", int'(bus.rom_addr), pin_rom);
                chk("pin_depth", int'(bus.depth), pin_depth);
                chk("pin_overflow", int'(bus.overflow), pin_ovf);
            end
        end
    end

    // ---------------- stimulus ----------------
    int pcs [8] = '{'h01, 'h03, 'h07, 'h0F, 'h1F, 'h3F, 'h3E, 'h3D};

    initial begin
        chk_en = 1'b0; pin_valid = 1'b0;
        reset = 1'b1; bus.op_valid = 1'b0; bus.op = 3'd0; bus.op_arg = 6'd0; bus.status = 1'b0;
        model_apply(1'b1, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        stepx(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 'h300, 0, 0);

        // LFSR walk from reset
        for (int i = 0; i < 8; i++) stepp(0, 0, 1'b0, 'h300 | pcs[i], 0, 0);

        // page buffer and conditional branch
        stepp(4, 5, 1'b0, 'h33B, 0, 0);
        stepp(1, 'h12, 1'b0, 'h337, 0, 0);
        stepp(1, 'h12, 1'b1, 'h152, 0, 0);

        // two-level calls, overflow, returns
        stepp(4, 3, 1'b0, 'h164, 0, 0);
        stepp(1, 'h03, 1'b1, 'h0C3, 0, 0);
        stepp(4, 6, 1'b0, 'h0C7, 0, 0);
        stepp(2, 'h20, 1'b1, 'h1A0, 1, 0);
        stepp(4, 9, 1'b0, 'h180, 1, 0);
        stepp(2, 'h10, 1'b1, 'h250, 2, 0);
        stepp(2, 'h05, 1'b1, 'h245, 2, 1);
        stepp(3, 0, 1'b0, 'h181, 1, 1);
        stepp(3, 0, 1'b0, 'h0CF, 0, 1);

        // reset in a depth-2 subroutine, with a CALL presented
        stepp(2, 'h11, 1'b1, 'h0D1, 1, 1);
        stepp(2, 'h22, 1'b1, 'h0E2, 2, 1);
        stepx(1'b1, 1'b1, 2, 'h05, 1'b1, 1'b1, 'h300, 0, 0);

        // chapter switching across call/return
        stepp(5, 0, 1'b0, 'h301, 0, 0);
        stepp(1, 'h00, 1'b1, 'h700, 0, 0);
        stepp(5, 0, 1'b0, 'h701, 0, 0);
        stepp(2, 'h08, 1'b1, 'h308, 1, 0);
        stepp(3, 0, 1'b0, 'h703, 0, 0);
        stepp(5, 0, 1'b0, 'h707, 0, 0);
        stepp(1, 'h00, 1'b1, 'h300, 0, 0);

        // return with empty stack, idle cycle, reserved op
        stepp(4, 'hA, 1'b0, 'h301, 0, 0);
        stepp(3, 0, 1'b0, 'h283, 0, 0);
        stepx(1'b0, 1'b0, 2, 'h15, 1'b1, 1'b1, 'h283, 0, 0);
        stepp(6, 'h3F, 1'b1, 'h287, 0, 0);
        stepp(7, 'h3F, 1'b1, 'h28F, 0, 0);

        // mixed op stream checked against the model only
        for (int i = 0; i < 60; i++) begin
            stepx(1'b0, 1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
